// File: rtl/spi_reg_cmd_decoder_if.sv
// Byte-stream and register-bus signals between the SPI command decoder and its neighbours.
// Signal names keep the decoder's own port naming; the decoder uses the slave modport.
interface spi_reg_cmd_decoder_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic [6:0] o_Reg_Addr;
  logic       o_Reg_Wr_En;
  logic [7:0] o_Reg_Wr_Data;
  logic       o_Reg_Rd_En;
  logic [7:0] i_Reg_Rd_Data;
  logic       o_Overrun;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Reg_Rd_Data,
    output o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En, o_Overrun
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_Reg_Rd_Data,
    input  o_TX_DV, o_TX_Byte, o_Reg_Addr, o_Reg_Wr_En, o_Reg_Wr_Data, o_Reg_Rd_En, o_Overrun
  );
endinterface

// File: rtl/spi_reg_cmd_decoder.sv
// Turns CS-framed SPI bytes (command byte + burst data) into register reads/writes,
// with auto-incrementing address and one-byte read prefetch back onto MISO.
module spi_reg_cmd_decoder #(
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_SPI_CS_n,
  spi_reg_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, RD_FETCH, READ} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       cs_meta_q, cs_s_q, cs_prev_q;
  logic       cs_fall, cs_rise;
  logic       prime_q;
  logic [6:0] addr_q, addr_d;
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_en_q, rd_en_d;
  logic       overrun_q, overrun_d;
  logic       fetch_done;

  // Synchronizer idles high so a reset never fabricates a CS edge.
  assign cs_fall    = cs_prev_q & ~cs_s_q;
  assign cs_rise    = ~cs_prev_q & cs_s_q;
  assign fetch_done = (state_q == RD_FETCH) && (cnt_q == LAT);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cs_fall) state_d = CMD;
      CMD:      if (bus.i_RX_DV) state_d = bus.i_RX_Byte[7] ? RD_FETCH : WRITE;
      WRITE:    state_d = WRITE;
      RD_FETCH: if (cnt_q == LAT) state_d = READ;
      READ:     if (bus.i_RX_DV) state_d = RD_FETCH;
      default:  state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
    cnt_d = (state_q == RD_FETCH && state_d == RD_FETCH) ? cnt_q + 3'd1 : 3'd0;
  end

  always_comb begin
    tx_dv_d    = prime_q;
    tx_byte_d  = prime_q ? STATUS_BYTE : tx_byte_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    overrun_d  = overrun_q & ~cs_fall;
    unique case (state_q)
      CMD: if (bus.i_RX_DV) begin
        addr_d = bus.i_RX_Byte[6:0];
        if (bus.i_RX_Byte[7]) begin
          rd_en_d    = 1'b1;
          reg_addr_d = bus.i_RX_Byte[6:0];
        end
      end
      WRITE: if (bus.i_RX_DV) begin
        wr_en_d    = 1'b1;
        wr_data_d  = bus.i_RX_Byte;
        reg_addr_d = addr_q;
        addr_d     = addr_q + 7'd1;
      end
      RD_FETCH: begin
        if (bus.i_RX_DV) overrun_d = 1'b1;
        // A CS release in the capture cycle abandons the prefetched byte.
        if (fetch_done && !cs_rise) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = bus.i_Reg_Rd_Data;
          addr_d    = addr_q + 7'd1;
        end
      end
      READ: if (bus.i_RX_DV) begin
        rd_en_d    = 1'b1;
        reg_addr_d = addr_q;
      end
      default: ;
    endcase
    if (cs_rise) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = STATUS_BYTE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      cs_prev_q  <= 1'b1;
      prime_q    <= 1'b1;
      addr_q     <= 7'd0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= STATUS_BYTE;
      reg_addr_q <= 7'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'd0;
      rd_en_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cs_meta_q  <= i_SPI_CS_n;
      cs_s_q     <= cs_meta_q;
      cs_prev_q  <= cs_s_q;
      prime_q    <= 1'b0;
      addr_q     <= addr_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_TX_DV       = tx_dv_q;
  assign bus.o_TX_Byte     = tx_byte_q;
  assign bus.o_Reg_Addr    = reg_addr_q;
  assign bus.o_Reg_Wr_En   = wr_en_q;
  assign bus.o_Reg_Wr_Data = wr_data_q;
  assign bus.o_Reg_Rd_En   = rd_en_q;
  assign bus.o_Overrun     = overrun_q;

endmodule

// File: tb/tb_spi_reg_cmd_decoder.sv
// Scoreboard bench: two decoders (read latency 1 and 4) driven with directed SPI byte streams.
module tb_spi_reg_cmd_decoder;

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst1, rst4, cs1_n, cs4_n;
  int checks = 0;
  int failures = 0;

  spi_reg_cmd_decoder_if b1();
  spi_reg_cmd_decoder_if b4();

  spi_reg_cmd_decoder #(.RD_LATENCY(1), .STATUS_BYTE(8'hA5)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst1), .i_SPI_CS_n(cs1_n), .bus(b1)
  );
  spi_reg_cmd_decoder #(.RD_LATENCY(4), .STATUS_BYTE(8'hA5)) u_dut4 (
    .i_Clk(clk), .i_Rst(rst4), .i_SPI_CS_n(cs4_n), .bus(b4)
  );

  // Register models: read data = addr + 0x40, valid only in the cycle RD_LATENCY after the strobe.
  logic       pv1 = 1'b0;
  logic [6:0] pa1 = 7'd0;
  logic       pv4 [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] pa4 [4] = '{7'd0, 7'd0, 7'd0, 7'd0};

  always @(posedge clk) begin
    pv1 <= b1.o_Reg_Rd_En;
    pa1 <= b1.o_Reg_Addr;
    pv4[0] <= b4.o_Reg_Rd_En;
    pa4[0] <= b4.o_Reg_Addr;
    for (int i = 1; i < 4; i++) begin
      pv4[i] <= pv4[i-1];
      pa4[i] <= pa4[i-1];
    end
  end

  assign b1.i_Reg_Rd_Data = (pv1 === 1'b1) ? {1'b0, pa1} + 8'h40 : 8'hEE;
  assign b4.i_Reg_Rd_Data = (pv4[3] === 1'b1) ? {1'b0, pa4[3]} + 8'h40 : 8'hEE;

  evt_t wq1[$], rq1[$], tq1[$];
  evt_t wq4[$], rq4[$], tq4[$];

  function automatic evt_t ev(input int c, input logic [6:0] a, input logic [7:0] d);
    evt_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic cmp(input string nm, input int n, input evt_t e, input logic [6:0] ga,
                     input logic [7:0] gd, input bit ca, input bit cd);
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL %s: unexpected strobe at cyc=%0d addr=%h data=%h, none required", nm, cyc, ga, gd);
    end else if (e.cyc != cyc || (ca && ga !== e.addr) || (cd && gd !== e.data)) begin
      failures++;
      $display("FAIL %s: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
               nm, cyc, ga, gd, e.cyc, e.addr, e.data);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // Monitor: every strobe the DUTs present is matched against the next expected event.
  always @(negedge clk) begin
    evt_t e;
    int n;
    if (b1.o_Reg_Wr_En === 1'b1 || b1.o_Reg_Rd_En === 1'b1)
      chk("d1_strobe_excl", {31'd0, b1.o_Reg_Wr_En & b1.o_Reg_Rd_En}, 32'd0);
    if (b4.o_Reg_Wr_En === 1'b1 || b4.o_Reg_Rd_En === 1'b1)
      chk("d4_strobe_excl", {31'd0, b4.o_Reg_Wr_En & b4.o_Reg_Rd_En}, 32'd0);
    if (b1.o_Reg_Wr_En === 1'b1) begin
      n = wq1.size(); e = ev(0, 0, 0); if (n > 0) e = wq1.pop_front();
      cmp("d1_wr", n, e, b1.o_Reg_Addr, b1.o_Reg_Wr_Data, 1'b1, 1'b1);
    end
    if (b1.o_Reg_Rd_En === 1'b1) begin
      n = rq1.size(); e = ev(0, 0, 0); if (n > 0) e = rq1.pop_front();
      cmp("d1_rd", n, e, b1.o_Reg_Addr, 8'h00, 1'b1, 1'b0);
    end
    if (b1.o_TX_DV === 1'b1) begin
      n = tq1.size(); e = ev(0, 0, 0); if (n > 0) e = tq1.pop_front();
      cmp("d1_tx", n, e, 7'h00, b1.o_TX_Byte, 1'b0, 1'b1);
    end
    if (b4.o_Reg_Wr_En === 1'b1) begin
      n = wq4.size(); e = ev(0, 0, 0); if (n > 0) e = wq4.pop_front();
      cmp("d4_wr", n, e, b4.o_Reg_Addr, b4.o_Reg_Wr_Data, 1'b1, 1'b1);
    end
    if (b4.o_Reg_Rd_En === 1'b1) begin
      n = rq4.size(); e = ev(0, 0, 0); if (n > 0) e = rq4.pop_front();
      cmp("d4_rd", n, e, b4.o_Reg_Addr, 8'h00, 1'b1, 1'b0);
    end
    if (b4.o_TX_DV === 1'b1) begin
      n = tq4.size(); e = ev(0, 0, 0); if (n > 0) e = tq4.pop_front();
      cmp("d4_tx", n, e, 7'h00, b4.o_TX_Byte, 1'b0, 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one RX_DV pulse for the cycle starting now (the current value of cyc).
  task automatic rx(input bit s4, input logic [7:0] b);
    if (s4) begin b4.i_RX_DV = 1'b1; b4.i_RX_Byte = b; end
    else    begin b1.i_RX_DV = 1'b1; b1.i_RX_Byte = b; end
    @(negedge clk);
    b1.i_RX_DV = 1'b0;
    b4.i_RX_DV = 1'b0;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_tx_dv"},   {31'd0, b1.o_TX_DV},     32'd0);
    chk({tag, "_tx_byte"}, {24'd0, b1.o_TX_Byte},   32'hA5);
    chk({tag, "_addr"},    {25'd0, b1.o_Reg_Addr},  32'd0);
    chk({tag, "_wr_en"},   {31'd0, b1.o_Reg_Wr_En}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, b1.o_Reg_Wr_Data}, 32'd0);
    chk({tag, "_rd_en"},   {31'd0, b1.o_Reg_Rd_En}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, b1.o_Overrun},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; cs1_n = 1'b1; cs4_n = 1'b1;
    b1.i_RX_DV = 1'b0; b1.i_RX_Byte = 8'h00;
    b4.i_RX_DV = 1'b0; b4.i_RX_Byte = 8'h00;
    tick(3);

    // Reset state, then one priming pulse per decoder.
    chk_reset1("rst");
    tq1.push_back(ev(cyc + 1, 7'h00, 8'hA5));
    tq4.push_back(ev(cyc + 1, 7'h00, 8'hA5));
    rst1 = 1'b0; rst4 = 1'b0;
    tick(4);
    chk("idle_tx_dv",  {31'd0, b1.o_TX_DV},   32'd0);
    chk("idle_overrun", {31'd0, b1.o_Overrun}, 32'd0);

    // Write burst at address 5.
    cs1_n = 1'b0; tick(4);
    rx(1'b0, 8'h05);
    wq1.push_back(ev(cyc + 1, 7'h05, 8'h11)); rx(1'b0, 8'h11);
    wq1.push_back(ev(cyc + 1, 7'h06, 8'h22)); rx(1'b0, 8'h22);
    wq1.push_back(ev(cyc + 1, 7'h07, 8'h33)); rx(1'b0, 8'h33);
    tick(2);
    tq1.push_back(ev(cyc + 3, 7'h00, 8'hA5));
    cs1_n = 1'b1; tick(5);

    // Read burst at address 2, latency 1; CS release cancels the third fetch.
    cs1_n = 1'b0; tick(4);
    rq1.push_back(ev(cyc + 1, 7'h02, 8'h00));
    tq1.push_back(ev(cyc + 3, 7'h00, 8'h42));
    rx(1'b0, 8'h82); tick(4);
    rq1.push_back(ev(cyc + 1, 7'h03, 8'h00));
    tq1.push_back(ev(cyc + 3, 7'h00, 8'h43));
    rx(1'b0, 8'h00); tick(4);
    rq1.push_back(ev(cyc + 1, 7'h04, 8'h00));
    tq1.push_back(ev(cyc + 3, 7'h00, 8'hA5));
    cs1_n = 1'b1;
    rx(1'b0, 8'h00); tick(5);

    // Address wrap; the last byte coincides with the CS rising edge.
    cs1_n = 1'b0; tick(4);
    rx(1'b0, 8'h7F);
    wq1.push_back(ev(cyc + 1, 7'h7F, 8'hAA)); rx(1'b0, 8'hAA);
    cs1_n = 1'b1; tick(2);
    wq1.push_back(ev(cyc + 1, 7'h00, 8'hBB));
    tq1.push_back(ev(cyc + 1, 7'h00, 8'hA5));
    rx(1'b0, 8'hBB); tick(5);

    // Overrun on the latency-4 decoder.
    cs4_n = 1'b0; tick(4);
    rq4.push_back(ev(cyc + 1, 7'h10, 8'h00));
    tq4.push_back(ev(cyc + 6, 7'h00, 8'h50));
    rx(1'b1, 8'h90);
    tick(1);
    chk("ovr_before", {31'd0, b4.o_Overrun}, 32'd0);
    tick(1);
    rx(1'b1, 8'h55);
    chk("ovr_set", {31'd0, b4.o_Overrun}, 32'd1);
    tick(6);
    tq4.push_back(ev(cyc + 3, 7'h00, 8'hA5));
    cs4_n = 1'b1; tick(5);
    chk("ovr_sticky", {31'd0, b4.o_Overrun}, 32'd1);
    cs4_n = 1'b0; tick(2);
    chk("ovr_hold_sync", {31'd0, b4.o_Overrun}, 32'd1);
    tick(1);
    chk("ovr_cleared", {31'd0, b4.o_Overrun}, 32'd0);
    tq4.push_back(ev(cyc + 3, 7'h00, 8'hA5));
    cs4_n = 1'b1; tick(5);

    // Reset in the middle of a write burst.
    cs1_n = 1'b0; tick(4);
    rx(1'b0, 8'h20);
    wq1.push_back(ev(cyc + 1, 7'h20, 8'h01)); rx(1'b0, 8'h01);
    rst1 = 1'b1;
    rx(1'b0, 8'h02);
    chk_reset1("midrst");
    cs1_n = 1'b1; tick(1);
    tq1.push_back(ev(cyc + 1, 7'h00, 8'hA5));
    rst1 = 1'b0; tick(2);
    rx(1'b0, 8'h33);
    rx(1'b0, 8'h44);
    tick(6);

    chk("d1_wr_left", wq1.size(), 32'd0);
    chk("d1_rd_left", rq1.size(), 32'd0);
    chk("d1_tx_left", tq1.size(), 32'd0);
    chk("d4_rd_left", rq4.size(), 32'd0);
    chk("d4_tx_left", tq4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_cmd_decoder.md
Name: spi_reg_cmd_decoder

Overview:
Sits directly downstream of SPI_Slave. It consumes the byte stream on o_RX_DV/o_RX_Byte and turns it into register-bus reads and writes. Read data goes back to the slave's i_TX_DV/i_TX_Byte for shifting out on MISO. The first byte of each CS-framed transaction is a command; all following bytes are burst data with address auto-increment.

Parameters:
RD_LATENCY, 1, register-bus read latency in i_Clk cycles from o_Reg_Rd_En to valid i_Reg_Rd_Data; legal range 1..4
STATUS_BYTE, 8'hA5, byte preloaded into the slave so it is returned on MISO during every command byte

Ports:
i_Clk  in  1  system clock; same clock as SPI_Slave i_Clk
i_Rst  in  1  synchronous reset, active-high
i_SPI_CS_n  in  1  chip select from SPI pins; asynchronous, synchronized internally
i_RX_DV  in  1  one-cycle pulse from slave o_RX_DV
i_RX_Byte  in  8  byte from slave o_RX_Byte
o_TX_DV  out  1  one-cycle load pulse to slave i_TX_DV
o_TX_Byte  out  8  byte to slave i_TX_Byte
o_Reg_Addr  out  7  register address
o_Reg_Wr_En  out  1  one-cycle write strobe
o_Reg_Wr_Data  out  8  write data, valid with o_Reg_Wr_En
o_Reg_Rd_En  out  1  one-cycle read strobe
i_Reg_Rd_Data  in  8  read data, valid RD_LATENCY cycles after o_Reg_Rd_En
o_Overrun  out  1  sticky: a byte arrived while a read fetch was still pending

Behaviour:
- Clocking and reset: one clock, i_Clk. i_Rst is synchronous and active-high.
- Reset values: o_TX_DV=0, o_TX_Byte=STATUS_BYTE, o_Reg_Addr=0, o_Reg_Wr_En=0, o_Reg_Wr_Data=0, o_Reg_Rd_En=0, o_Overrun=0, state=IDLE.
- Priming after reset: in the first cycle after i_Rst deasserts, o_TX_DV pulses once with STATUS_BYTE.
- CS synchronization: i_SPI_CS_n passes through a 2-flop synchronizer, giving cs_s. Falling and rising edges are detected on cs_s.
- Reset mid-operation: aborts any burst; no strobes are issued after reset.
- States: IDLE, CMD, WRITE, RD_FETCH, READ.
- IDLE:
  - cs_s falling edge -> CMD.
  - i_RX_DV in IDLE is ignored.
- CMD: on i_RX_DV (cycle T), latch addr=i_RX_Byte[6:0].
  - Bit 7 = 0 (write): go to WRITE.
  - Bit 7 = 1 (read): assert o_Reg_Rd_En at T+1 with o_Reg_Addr=addr, then go to RD_FETCH.
- WRITE: each i_RX_DV at cycle T gives o_Reg_Wr_En=1 at T+1, with o_Reg_Wr_Data=i_RX_Byte and o_Reg_Addr=current addr. addr then increments.
- RD_FETCH: count RD_LATENCY cycles, then register i_Reg_Rd_Data into o_TX_Byte.
  - o_TX_DV pulses in that same cycle, i.e. T+2+RD_LATENCY relative to the triggering i_RX_DV.
  - addr increments, then go to READ.
- READ: each i_RX_DV (dummy byte; the previous TX byte has been shifted out) issues o_Reg_Rd_En at T+1 on the current addr, then returns to RD_FETCH.
  - The received byte value is discarded.
  - Data is presented one byte later on MISO: byte n of the burst returns addr+n-1. This is the standard one-byte prefetch lag.
- Address arithmetic: 7-bit, increments after every write or read fetch, wraps 7'h7F -> 7'h00 with no flag.
- Overrun: i_RX_DV while in RD_FETCH sets o_Overrun. That byte is dropped; the fetch completes normally.
  - o_Overrun clears on the next cs_s falling edge or on i_Rst.
- CS rising edge, from any state:
  - -> IDLE.
  - Pending fetch is abandoned: no o_TX_DV for it.
  - o_TX_DV pulses the next cycle with o_TX_Byte=STATUS_BYTE, priming the next command byte.
  - An o_Reg_Wr_En already scheduled for T+1 still completes.
- Simultaneous events:
  - CS rising edge and i_RX_DV in the same cycle: the byte is processed (write/read strobe issued), then -> IDLE.
  - CS falling edge and rising edge cannot both occur in one cycle, because of the synchronizer.
- Strobe rules: o_Reg_Wr_En and o_Reg_Rd_En are never high in the same cycle, and each is exactly one cycle wide.

Test Plan:
1. Reset then idle -> single o_TX_DV pulse with o_TX_Byte=8'hA5; all strobes 0; o_Overrun=0.
2. CS low, RX bytes 8'h05, 8'h11, 8'h22, 8'h33, CS high -> three o_Reg_Wr_En pulses at addr 5/6/7 with data 11/22/33, each at RX_DV+1; then STATUS prime pulse.
3. Read burst: CS low, RX 8'h82 then two dummy bytes, register model returns addr+8'h40, RD_LATENCY=1 -> o_Reg_Rd_En at addr 2, 3, 4; o_TX_DV with 8'h42 at T+3 after the command, then 8'h43; CS high cancels the addr-4 fetch; 8'hA5 reprimed.
4. Wrap: write command 8'h7F plus 2 data bytes -> writes at 7'h7F then 7'h00.
5. Overrun: RD_LATENCY=4, second RX_DV injected 2 cycles after first read strobe -> o_Overrun=1, no extra o_Reg_Rd_En; cleared at next CS falling edge.
6. i_Rst asserted mid write burst -> all outputs at reset values next cycle; subsequent RX_DV with CS high produces no strobes.
